// File: rtl/ro_ctrl_pkg.sv
// ro_ctrl_pkg: shared FSM encodings and counter helper for the ring-oscillator measurement controller
package ro_ctrl_pkg;
    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [ST_W-1:0] ST_SETTLE = 2'd1;
    localparam logic [ST_W-1:0] ST_GATE   = 2'd2;
    localparam logic [ST_W-1:0] ST_REPORT = 2'd3;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return v >= max ? max : v + 32'd1;
    endfunction
endpackage

// File: rtl/ro_edge_sync.sv
// ro_edge_sync: 2-flop synchroniser plus a history flop giving a one-cycle rising-edge pulse
module ro_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic [2:0] s;

    always_ff @(posedge clk) begin
        if (rst) s <= '0;
        else s <= {s[1:0], d};
    end

    assign rise = s[1] & ~s[2];
endmodule

// File: rtl/ro_measure_ctrl.sv
// ro_measure_ctrl: enables one ring oscillator at a time, settles it, counts its edges over a gate window
module ro_measure_ctrl
    import ro_ctrl_pkg::*;
#(
    parameter int NUM_RO        = 4,
    parameter int SEL_W         = NUM_RO > 1 ? $clog2(NUM_RO) : 1,
    parameter int CNT_W         = 16,
    parameter int GATE_W        = 16,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              scan,
    input  logic [SEL_W-1:0]  ro_sel,
    input  logic [GATE_W-1:0] gate_len,
    input  logic [NUM_RO-1:0] ro_clk_in,
    output logic [NUM_RO-1:0] ro_en,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  res_count,
    output logic [SEL_W-1:0]  res_id,
    output logic              res_ovf
);
    localparam int SW1 = SEL_W + 1;
    localparam logic [SEL_W:0]    ro_last     = SW1'(NUM_RO - 1);
    localparam logic [CNT_W-1:0]  cnt_max     = '1;
    localparam logic [GATE_W-1:0] settle_last = GATE_W'(SETTLE_CYCLES - 1);

    logic [ST_W-1:0]   state, state_nxt;
    logic [SEL_W-1:0]  id, id_nxt;
    logic              scan_q;
    logic [GATE_W-1:0] gate_q, timer;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              ovf, ovf_nxt;
    logic [NUM_RO-1:0] edges;
    logic              start_go, settle_done, gate_done, hs, more, hit;

    for (genvar i = 0; i < NUM_RO; i++) begin : g_sync
        ro_edge_sync u_sync (.clk(clk), .rst(rst), .d(ro_clk_in[i]), .rise(edges[i]));
    end

    // Masking edges with ro_en keeps out-of-range ids from counting anything.
    always_comb begin
        start_go    = state == ST_IDLE && start;
        settle_done = state == ST_SETTLE && timer == settle_last;
        gate_done   = state == ST_GATE && timer == gate_q - 1'b1;
        hs          = state == ST_REPORT && res_valid && res_ready;
        more        = scan_q && {1'b0, id} < ro_last;
        hit         = state == ST_GATE && |(edges & ro_en);
        state_nxt   = start_go ? ST_SETTLE : settle_done ? ST_GATE : gate_done ? ST_REPORT :
                      hs ? (more ? ST_SETTLE : ST_IDLE) : state;
        id_nxt      = start_go ? (scan ? '0 : ro_sel) : (hs && more) ? id + 1'b1 : id;
        cnt_nxt     = state == ST_SETTLE ? '0 : hit ? CNT_W'(sat_inc(32'(cnt), 32'(cnt_max))) : cnt;
        ovf_nxt     = state == ST_SETTLE ? 1'b0 : ovf | (hit && cnt == cnt_max);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            id        <= '0;
            scan_q    <= 1'b0;
            gate_q    <= '0;
            timer     <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            ro_en     <= '0;
            res_valid <= 1'b0;
            res_count <= '0;
            res_id    <= '0;
            res_ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            id    <= id_nxt;
            timer <= state_nxt != state ? '0 : timer + 1'b1;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
            ro_en <= (state_nxt == ST_SETTLE || state_nxt == ST_GATE) ? NUM_RO'(1) << id_nxt : '0;
            if (start_go) begin
                scan_q <= scan;
                gate_q <= gate_len == '0 ? GATE_W'(1) : gate_len;
            end
            if (gate_done) begin
                res_valid <= 1'b1;
                res_count <= cnt_nxt;
                res_id    <= id;
                res_ovf   <= ovf_nxt;
            end else if (hs) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign busy = state != ST_IDLE;
endmodule
